// File: rtl/fifo_arb_pkg.sv
// Purpose : shared state type and default sizing for the FIFO write arbiter.
// Latency : n/a (types and constants only).
// Backpressure : n/a.
package fifo_arb_pkg;

    // Two-state grant FSM: waiting for a requester, or owned by one.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Purpose : round-robin picker, first valid index above last_grant with wrap.
// Latency : purely combinational.
// Backpressure : none; the caller decides when to register the pick.
//
// Ports:
//   valid      - per-requester valid flags
//   last_grant - index that most recently owned the FIFO
//   pick       - chosen index (0 when nothing is valid)
//   any_valid  - at least one valid flag is set
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [$clog2(NUM_REQ)-1:0] pick,
    output logic                       any_valid
);

    localparam int GW = $clog2(NUM_REQ);

    // One extra bit so last_grant + k never overflows before the wrap.
    logic [GW:0]   sum;
    logic [GW-1:0] cand;

    always_comb begin
        pick      = '0;
        any_valid = 1'b0;
        sum       = '0;
        cand      = '0;
        // k = NUM_REQ lands back on last_grant itself, so it is searched last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, last_grant} + (GW+1)'(k);
            if (sum >= (GW+1)'(NUM_REQ)) begin
                sum = sum - (GW+1)'(NUM_REQ);
            end
            cand = sum[GW-1:0];
            if (!any_valid && valid[cand]) begin
                any_valid = 1'b1;
                pick      = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Purpose : round-robin arbiter granting one of NUM_REQ writers bursts of up to MAX_BURST FIFO writes.
// Latency : one cycle from request in IDLE to grant; data/enable/ready paths are combinational in BURST.
// Backpressure : fifo_w_ready low holds the burst and is passed straight to the owner's req_ready.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   req_valid/req_data       - per-requester write request, requester i at bits [i*WIDTH +: WIDTH]
//   req_ready                - accept flag, only ever set for the current owner
//   fifo_sel/fifo_w_enable/fifo_w_data/fifo_w_ready - FIFO write port
//   grant_id/busy            - current (or most recent) owner, grant held
//   xfer_count               - free-running count of accepted writes, wraps at 2^16
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       fifo_sel,
    output logic                       fifo_w_enable,
    output logic [WIDTH-1:0]           fifo_w_data,
    input  logic                       fifo_w_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [15:0]                xfer_count
);

    localparam int GW = $clog2(NUM_REQ);

    arb_state_t       state;
    logic [GW-1:0]    last_grant;
    logic [GW-1:0]    pick;
    logic             any_valid;
    logic [3:0]       burst_cnt;
    logic [15:0]      xfer_cnt_q;
    logic [WIDTH-1:0] data_arr [NUM_REQ];
    logic             grant_valid;
    logic             xfer;
    logic             last_beat;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .valid      (req_valid),
        .last_grant (last_grant),
        .pick       (pick),
        .any_valid  (any_valid)
    );

    assign grant_valid = req_valid[grant_id];
    assign xfer        = (state == BURST) && grant_valid && fifo_w_ready;
    // burst_cnt counts completed transfers, so the final one sees MAX_BURST-1.
    assign last_beat   = (burst_cnt == 4'(MAX_BURST - 1));
    assign xfer_count  = xfer_cnt_q;

    // Outputs decode only from state so everything reads 0 while reset is held.
    always_comb begin
        fifo_sel      = 1'b0;
        fifo_w_enable = 1'b0;
        fifo_w_data   = '0;
        req_ready     = '0;
        busy          = 1'b0;
        if (state == BURST) begin
            fifo_sel            = 1'b1;
            busy                = 1'b1;
            fifo_w_enable       = grant_valid;
            fifo_w_data         = data_arr[grant_id];
            req_ready[grant_id] = fifo_w_ready;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            burst_cnt  <= '0;
            xfer_cnt_q <= '0;
        end else begin
            if (xfer) begin
                xfer_cnt_q <= xfer_cnt_q + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_id <= pick;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    // A stalled FIFO never ends the grant; only a dropped
                    // valid or the final beat does.
                    if (!grant_valid || (xfer && last_beat)) begin
                        state      <= IDLE;
                        last_grant <= grant_id;
                        burst_cnt  <= '0;
                    end else if (xfer) begin
                        burst_cnt <= burst_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int GW        = $clog2(NUM_REQ);

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_sel;
    logic                     fifo_w_enable;
    logic [WIDTH-1:0]         fifo_w_data;
    logic                     fifo_w_ready = 1'b0;
    logic [GW-1:0]            grant_id;
    logic                     busy;
    logic [15:0]              xfer_count;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_sel      (fifo_sel),
        .fifo_w_enable (fifo_w_enable),
        .fifo_w_data   (fifo_w_data),
        .fifo_w_ready  (fifo_w_ready),
        .grant_id      (grant_id),
        .busy          (busy),
        .xfer_count    (xfer_count)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the FIFO, how many beats it has had, who
    // owned it last, the most recently granted id and the running total.
    int m_owner, m_beats, m_last, m_gid, m_count;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner = -1;
            m_beats = 0;
            m_last  = NUM_REQ - 1;
            m_gid   = 0;
            m_count = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (m_owner < 0 && req_valid[(m_last + k) % NUM_REQ]) begin
                    m_owner = (m_last + k) % NUM_REQ;
                    m_gid   = m_owner;
                end
            end
        end else if (!req_valid[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
            m_beats = 0;
        end else if (fifo_w_ready) begin
            m_count = (m_count + 1) % 65536;
            m_beats = m_beats + 1;
            if (m_beats == MAX_BURST) begin
                m_last  = m_owner;
                m_owner = -1;
                m_beats = 0;
            end
        end
    end

    // Advance one clock; inputs change and outputs are sampled 2-3 units later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        req_valid    = '0;
        fifo_w_ready = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        req_valid    = 4'b1111;
        fifo_w_ready = 1'b1;
        req_data     = $urandom;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if ({busy, fifo_sel, fifo_w_enable, req_ready, grant_id, xfer_count, fifo_w_data} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: busy=%b sel=%b en=%b ready=%b gid=%0d cnt=%0d data=%h, required all 0",
                         c, busy, fifo_sel, fifo_w_enable, req_ready, grant_id, xfer_count, fifo_w_data);
            end
            tick();
        end
    endtask

    task automatic test_single_requester();
        int beats;
        do_reset();
        req_valid    = 4'b0001;
        fifo_w_ready = 1'b1;
        req_data     = $urandom;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle_first busy=%b, required 0", busy);
        end
        tick();
        n_checks++;
        if ({busy, fifo_sel, fifo_w_enable, req_ready, grant_id} !== {1'b1, 1'b1, 1'b1, 4'b0001, GW'(0)}) begin
            n_fail++;
            $display("FAIL single_grant busy=%b sel=%b en=%b ready=%b gid=%0d, required 1 1 1 0001 0",
                     busy, fifo_sel, fifo_w_enable, req_ready, grant_id);
        end
        n_checks++;
        if (fifo_w_data !== req_data[WIDTH-1:0]) begin
            n_fail++;
            $display("FAIL single_data got %h, required %h", fifo_w_data, req_data[WIDTH-1:0]);
        end
        beats = 0;
        while (busy === 1'b1 && beats < 10) begin
            beats++;
            tick();
        end
        n_checks++;
        if (beats != MAX_BURST || xfer_count !== 16'd4) begin
            n_fail++;
            $display("FAIL single_burst beats=%0d cnt=%0d, required 4 and 4", beats, xfer_count);
        end
        tick();
        n_checks++;
        if (busy !== 1'b1 || grant_id !== GW'(0)) begin
            n_fail++;
            $display("FAIL single_regrant busy=%b gid=%0d, required 1 and 0", busy, grant_id);
        end
    endtask

    task automatic test_round_robin();
        int beats;
        do_reset();
        req_valid    = 4'b1111;
        fifo_w_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            req_data = $urandom;
            tick();
            n_checks++;
            if (busy !== 1'b1 || grant_id !== GW'(g % NUM_REQ)) begin
                n_fail++;
                $display("FAIL rr_order grant #%0d busy=%b gid=%0d, required 1 and %0d", g, busy, grant_id, g % NUM_REQ);
            end
            beats = 0;
            while (busy === 1'b1 && beats < 10) begin
                beats++;
                tick();
            end
            n_checks++;
            if (beats != MAX_BURST) begin
                n_fail++;
                $display("FAIL rr_beats grant #%0d got %0d beats, required %0d", g, beats, MAX_BURST);
            end
        end
        n_checks++;
        if (xfer_count !== 16'd20) begin
            n_fail++;
            $display("FAIL rr_total got %0d, required 20", xfer_count);
        end
    endtask

    task automatic test_backpressure();
        int beats;
        do_reset();
        req_valid    = 4'b0100;
        fifo_w_ready = 1'b1;
        req_data     = $urandom;
        tick();
        n_checks++;
        if (busy !== 1'b1 || grant_id !== GW'(2)) begin
            n_fail++;
            $display("FAIL bp_grant busy=%b gid=%0d, required 1 and 2", busy, grant_id);
        end
        tick();
        fifo_w_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if ({busy, fifo_w_enable, req_ready, xfer_count} !== {1'b1, 1'b1, 4'b0000, 16'd1}) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d busy=%b en=%b ready=%b cnt=%0d, required 1 1 0000 1",
                         c, busy, fifo_w_enable, req_ready, xfer_count);
            end
        end
        fifo_w_ready = 1'b1;
        #1;
        beats = 0;
        while (busy === 1'b1 && beats < 10) begin
            beats++;
            tick();
        end
        n_checks++;
        if (beats != 3 || xfer_count !== 16'd4) begin
            n_fail++;
            $display("FAIL bp_resume beats=%0d cnt=%0d, required 3 and 4", beats, xfer_count);
        end
    endtask

    task automatic test_valid_drop();
        do_reset();
        req_valid    = 4'b0010;
        fifo_w_ready = 1'b1;
        req_data     = $urandom;
        tick();
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b1 || grant_id !== GW'(1) || xfer_count !== 16'd2) begin
            n_fail++;
            $display("FAIL drop_pre busy=%b gid=%0d cnt=%0d, required 1 1 2", busy, grant_id, xfer_count);
        end
        req_valid = 4'b1101;
        #1;
        n_checks++;
        if (fifo_w_enable !== 1'b0 || req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL drop_enable en=%b ready=%b, required 0 and 0010", fifo_w_enable, req_ready);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || xfer_count !== 16'd2) begin
            n_fail++;
            $display("FAIL drop_idle busy=%b cnt=%0d, required 0 and 2", busy, xfer_count);
        end
        tick();
        n_checks++;
        if (busy !== 1'b1 || grant_id !== GW'(2)) begin
            n_fail++;
            $display("FAIL drop_next busy=%b gid=%0d, required 1 and 2", busy, grant_id);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_valid    = 4'b0001;
        fifo_w_ready = 1'b1;
        req_data     = $urandom;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({busy, fifo_sel, fifo_w_enable, req_ready, grant_id, xfer_count, fifo_w_data} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs busy=%b sel=%b en=%b ready=%b gid=%0d cnt=%0d data=%h, required all 0",
                     busy, fifo_sel, fifo_w_enable, req_ready, grant_id, xfer_count, fifo_w_data);
        end
        req_valid = 4'b1000;
        rst       = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b1 || grant_id !== GW'(3) || xfer_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rstmid_grant busy=%b gid=%0d cnt=%0d, required 1 3 0", busy, grant_id, xfer_count);
        end
        tick();
        n_checks++;
        if (xfer_count !== 16'd1) begin
            n_fail++;
            $display("FAIL rstmid_count got %0d, required 1", xfer_count);
        end
    endtask

    task automatic test_count_wrap();
        do_reset();
        force dut.xfer_cnt_q = 16'hFFFF;
        #1;
        release dut.xfer_cnt_q;
        m_count      = 65535;
        req_valid    = 4'b0001;
        fifo_w_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (xfer_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap got %h, required 0000", xfer_count);
        end
    endtask

    task automatic test_random();
        logic                 e_busy, e_en;
        logic [NUM_REQ-1:0]   e_ready;
        logic [WIDTH-1:0]     e_data;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) req_valid = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
            fifo_w_ready = ($urandom_range(0, 3) != 0);
            req_data     = $urandom;
            #1;
            e_busy  = (m_owner >= 0);
            e_en    = 1'b0;
            e_ready = '0;
            e_data  = '0;
            if (e_busy) begin
                e_en             = req_valid[m_owner];
                e_ready[m_owner] = fifo_w_ready;
                e_data           = req_data[m_owner*WIDTH +: WIDTH];
            end
            n_checks++;
            if ({busy, fifo_sel, fifo_w_enable, req_ready, fifo_w_data, grant_id, xfer_count} !==
                {e_busy, e_busy, e_en, e_ready, e_data, GW'(m_gid), 16'(m_count)}) begin
                n_fail++;
                $display("FAIL random cycle %0d got busy=%b en=%b ready=%b data=%h gid=%0d cnt=%0d, required busy=%b en=%b ready=%b data=%h gid=%0d cnt=%0d",
                         c, busy, fifo_w_enable, req_ready, fifo_w_data, grant_id, xfer_count,
                         e_busy, e_en, e_ready, e_data, m_gid, m_count);
            end
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_requester();
        test_round_robin();
        test_backpressure();
        test_valid_drop();
        test_reset_mid_burst();
        test_count_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
